// File: rtl/adder_11_reg.sv
// ---------------------------------------------------------------------------
// adder_11_reg
//
// Purpose:
//   Registered 3-bit + 3-bit adder with carry-in, producing a 4-bit sum.
//   This is a leaf arithmetic slice of the larger adder datapath. Operand
//   and sum bits are exposed as scalar ports, MSB-first.
//
//     A = {pi6,pi5,pi4}, B = {pi3,pi2,pi1}, carry-in = pi0
//     S = {po3,po2,po1,po0} = A + B + pi0   (max 7+7+1 = 15, never overflows)
//
// Ports:
//   clk              in   single clock, rising-edge
//   rst              in   synchronous, active-high reset
//   in_valid         in   qualifies pi6..pi0 this cycle
//   pi6..pi4         in   operand A, MSB to LSB
//   pi3..pi1         in   operand B, MSB to LSB
//   pi0              in   carry-in
//   out_valid        out  one-cycle pulse per accepted input
//   po3..po0         out  sum S, MSB to LSB (holds last value when idle)
//
// Configuration macro:
//   ADDER_11_PIPE_EN  defined   -> extra register stage, 2-cycle latency
//                     undefined -> single stage, 1-cycle latency
//   Sum values and throughput (1 result/cycle) are identical in both modes.
// ---------------------------------------------------------------------------
module adder_11_reg (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic pi6,
  input  logic pi5,
  input  logic pi4,
  input  logic pi3,
  input  logic pi2,
  input  logic pi1,
  input  logic pi0,
  output logic out_valid,
  output logic po3,
  output logic po2,
  output logic po1,
  output logic po0
);

  logic [2:0] w_a;
  logic [2:0] w_b;
  logic [3:0] w_sum;

  assign w_a   = {pi6, pi5, pi4};
  assign w_b   = {pi3, pi2, pi1};
  // Zero-extend every term to 4 bits so the carry lands in bit 3.
  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {3'b000, pi0};

  // Final (output) stage registers.
  logic [3:0] r_sum;
  logic       r_valid;

`ifdef ADDER_11_PIPE_EN
  // Capture stage: operands are summed and registered here, then moved to
  // the output stage one cycle later. Valid travels alongside the sum.
  logic [3:0] r_s1_sum;
  logic       r_s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_sum   <= 4'b0000;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      // Load only on valid so idle (possibly X) inputs never enter the pipe.
      if (in_valid) begin
        r_s1_sum <= w_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= 4'b0000;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_s1_valid;
      // Output holds its last value while the pipe carries a bubble.
      if (r_s1_valid) begin
        r_sum <= r_s1_sum;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= 4'b0000;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      // Load only on valid: holds on idle and keeps idle inputs out.
      if (in_valid) begin
        r_sum <= w_sum;
      end
    end
  end
`endif

  assign out_valid = r_valid;
  assign po3       = r_sum[3];
  assign po2       = r_sum[2];
  assign po1       = r_sum[1];
  assign po0       = r_sum[0];

endmodule

// File: tb/tb_adder_11_reg.sv
module tb_adder_11_reg;

`ifdef ADDER_11_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [6:0] pi_bus;
  logic       out_valid;
  logic       po3, po2, po1, po0;
  logic [3:0] po_bus;

  int n_checks;
  int n_errors;

  assign po_bus = {po3, po2, po1, po0};

  adder_11_reg dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .pi6      (pi_bus[6]),
    .pi5      (pi_bus[5]),
    .pi4      (pi_bus[4]),
    .pi3      (pi_bus[3]),
    .pi2      (pi_bus[2]),
    .pi1      (pi_bus[1]),
    .pi0      (pi_bus[0]),
    .out_valid(out_valid),
    .po3      (po3),
    .po2      (po2),
    .po1      (po1),
    .po0      (po0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    pi_bus   = 7'b1111111;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || po_bus !== 4'b0000) begin
        n_errors++;
        $display("FAIL reset_hold cycle %0d: out_valid=%b po=%b, required out_valid=0 po=0000",
                 k, out_valid, po_bus);
      end
    end
    rst      = 1'b0;
    in_valid = 1'b1;
    pi_bus   = 7'b0000001;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      n_checks++;
      if (out_valid !== (k == LAT)) begin
        n_errors++;
        $display("FAIL reset_first_latency k=%0d: out_valid=%b, required %b",
                 k, out_valid, (k == LAT));
      end
      if (k == LAT) begin
        n_checks++;
        if (po_bus !== 4'b0001) begin
          n_errors++;
          $display("FAIL reset_first_value: po=%b, required 0001", po_bus);
        end
      end
      tick();
    end
    $display("test_reset: pi=0000001 after reset, latency %0d", LAT);
  endtask

  task automatic test_corners();
    logic [6:0] vec [6];
    logic [3:0] exp [6];
    vec[0] = 7'b0000000; exp[0] = 4'b0000;
    vec[1] = 7'b0000001; exp[1] = 4'b0001;
    vec[2] = 7'b0000010; exp[2] = 4'b0001;
    vec[3] = 7'b1000000; exp[3] = 4'b0100;
    vec[4] = 7'b1111110; exp[4] = 4'b1110;
    vec[5] = 7'b1111111; exp[5] = 4'b1111;
    for (int v = 0; v < 6; v++) begin
      in_valid = 1'b1;
      pi_bus   = vec[v];
      tick();
      in_valid = 1'b0;
      pi_bus   = 7'($urandom);
      for (int k = 1; k <= LAT; k++) begin
        n_checks++;
        if (out_valid !== (k == LAT)) begin
          n_errors++;
          $display("FAIL corner_valid pi=%b k=%0d: out_valid=%b, required %b",
                   vec[v], k, out_valid, (k == LAT));
        end
        if (k < LAT) tick();
      end
      n_checks++;
      if (po_bus !== exp[v]) begin
        n_errors++;
        $display("FAIL corner_sum pi=%b: po=%b, required %b", vec[v], po_bus, exp[v]);
      end
      $display("test_corners: pi=%b po=%b", vec[v], po_bus);
      tick();
    end
    for (int k = 0; k < LAT; k++) tick();
  endtask

  task automatic test_back_to_back();
    int idx;
    int exp_i;
    for (int t = 0; t <= 127 + LAT; t++) begin
      if (t < 128) begin
        in_valid = 1'b1;
        pi_bus   = 7'(t);
      end else begin
        in_valid = 1'b0;
        pi_bus   = 7'($urandom);
      end
      tick();
      idx = t - LAT + 1;
      if (idx >= 0 && idx < 128) begin
        exp_i = ((idx >> 4) & 7) + ((idx >> 1) & 7) + (idx & 1);
        n_checks++;
        if (out_valid !== 1'b1 || po_bus !== 4'(exp_i)) begin
          n_errors++;
          $display("FAIL stream pi=%b: out_valid=%b po=%b, required out_valid=1 po=%b",
                   7'(idx), out_valid, po_bus, 4'(exp_i));
        end
      end else if (idx == 128) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL stream_end: out_valid=%b, required 0", out_valid);
        end
      end
    end
    $display("test_back_to_back: 128 values streamed");
    tick();
  endtask

  task automatic test_idle_hold();
    int pulses;
    pulses   = 0;
    in_valid = 1'b1;
    pi_bus   = 7'b0110101;
    tick();
    for (int k = 1; k <= LAT + 5; k++) begin
      in_valid = 1'b0;
      pi_bus   = 7'($urandom);
      if (out_valid === 1'b1) pulses++;
      if (k >= LAT) begin
        n_checks++;
        if (po_bus !== 4'b0110) begin
          n_errors++;
          $display("FAIL idle_hold k=%0d: po=%b, required 0110", k, po_bus);
        end
      end
      tick();
    end
    n_checks++;
    if (pulses !== 1) begin
      n_errors++;
      $display("FAIL idle_pulses: count=%0d, required 1", pulses);
    end
    $display("test_idle_hold: po=%b pulses=%0d", po_bus, pulses);
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1;
    pi_bus   = 7'b1010101;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k <= LAT + 1; k++) begin
      n_checks++;
      if (out_valid !== 1'b0 || po_bus !== 4'b0000) begin
        n_errors++;
        $display("FAIL mid_reset k=%0d: out_valid=%b po=%b, required out_valid=0 po=0000",
                 k, out_valid, po_bus);
      end
      tick();
    end
    $display("test_mid_reset: pi=1010101 dropped");
  endtask

  task automatic test_bubbles();
    logic       vseq [6];
    logic [6:0] pseq [6];
    logic [3:0] sseq [6];
    logic [3:0] exp_po;
    logic       exp_v;
    int         idx;
    // 0011011: 1+5+1 = 7 ; 1100100: 6+2+0 = 8
    vseq[0] = 1'b1; pseq[0] = 7'b0011011; sseq[0] = 4'b0111;
    vseq[1] = 1'b0; pseq[1] = 7'b1111111; sseq[1] = 4'b0000;
    vseq[2] = 1'b1; pseq[2] = 7'b1100100; sseq[2] = 4'b1000;
    vseq[3] = 1'b0; pseq[3] = 7'b0000000; sseq[3] = 4'b0000;
    vseq[4] = 1'b0; pseq[4] = 7'b1010101; sseq[4] = 4'b0000;
    vseq[5] = 1'b0; pseq[5] = 7'b0101010; sseq[5] = 4'b0000;
    exp_po = 4'b0000;
    for (int t = 0; t < 6; t++) begin
      in_valid = vseq[t];
      pi_bus   = pseq[t];
      tick();
      idx   = t - LAT + 1;
      exp_v = (idx >= 0) ? vseq[idx] : 1'b0;
      if (idx >= 0 && vseq[idx]) exp_po = sseq[idx];
      n_checks++;
      if (out_valid !== exp_v || po_bus !== exp_po) begin
        n_errors++;
        $display("FAIL bubbles t=%0d: out_valid=%b po=%b, required out_valid=%b po=%b",
                 t, out_valid, po_bus, exp_v, exp_po);
      end
      $display("test_bubbles: t=%0d in_valid=%b out_valid=%b po=%b", t, vseq[t], out_valid, po_bus);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    pi_bus   = 7'b0000000;
    test_reset();
    test_corners();
    test_back_to_back();
    test_idle_hold();
    test_mid_reset();
    test_bubbles();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
